key_event_arbiter: RTL and testbench

Front-end controller between the raw 12-bit `keystroke` bus and `core`. It synchronises and debounces every key line, turns presses into discrete key events, and optionally generates auto-repeat events for the most recently pressed held key. It delivers those events one at a time over a valid/ready handshake, using a round-robin arbiter so that simultaneous keys are served fairly. `core` then consumes a clean single-event stream instead of sampling raw levels.

---
 rtl/key_event_arbiter.sv | 159 +++++++++++++++
 tb/tb_key_event_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_arbiter.sv
// Key front end: synchronises and debounces raw key lines, generates press and
// auto-repeat events, and hands them to the core one at a time (round robin).
module key_event_arbiter #(
   parameter int N_KEYS     = 12,
   parameter int DB_CYCLES  = 1000,
   parameter int RPT_DELAY  = 50_000_000,
   parameter int RPT_PERIOD = 10_000_000,
   localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
   input  logic              clk_raw,
   input  logic              rst,
   input  logic [N_KEYS-1:0] keystroke,
   input  logic              rpt_en,
   input  logic              ev_ready,
   input  logic              ovf_clr,
   output logic              ev_valid,
   output logic [KW-1:0]     ev_key,
   output logic              ev_repeat,
   output logic [N_KEYS-1:0] key_state,
   output logic              ovf
);

   localparam int CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int TMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DELAY = 2'd1;
   localparam logic [1:0] S_RPT   = 2'd2;

   logic [N_KEYS-1:0] sync1, sync2, key_prev;
   logic [CW-1:0]     cnt [N_KEYS];
   logic [N_KEYS-1:0] pend, rep;
   logic [N_KEYS-1:0] press, set_vec, clr_vec;
   logic              press_any;
   logic [KW-1:0]     press_idx;
   logic [1:0]        state;
   logic [KW-1:0]     rpt_key;
   logic [TW-1:0]     tmr;
   logic              rpt_fire;
   logic              load, hit;
   logic [KW-1:0]     grant, last_grant;
   logic [KW:0]       sum;
   logic              ovf_set;

   // Simultaneous presses retarget the repeat engine to the lowest index.
   always_comb begin
      press     = key_state & ~key_prev;
      press_any = |press;
      press_idx = '0;
      for (int i = N_KEYS - 1; i >= 0; i--) begin
         if (press[i]) press_idx = KW'(i);
      end
   end

   always_comb begin
      rpt_fire = 1'b0;
      if (!press_any && state != S_IDLE && key_state[rpt_key] && rpt_en) begin
         if (state == S_DELAY && tmr == TW'(RPT_DELAY - 1)) rpt_fire = 1'b1;
         if (state == S_RPT && tmr == TW'(RPT_PERIOD - 1)) rpt_fire = 1'b1;
      end
   end

   // Round-robin search starting just after the previous grant.
   always_comb begin
      load  = !ev_valid || ev_ready;
      hit   = 1'b0;
      grant = '0;
      sum   = '0;
      for (int k = 1; k <= N_KEYS; k++) begin
         sum = {1'b0, last_grant} + (KW+1)'(k);
         if (sum >= (KW+1)'(N_KEYS)) sum = sum - (KW+1)'(N_KEYS);
         if (!hit && pend[sum[KW-1:0]]) begin
            hit   = 1'b1;
            grant = sum[KW-1:0];
         end
      end
   end

   always_comb begin
      set_vec = press | (rpt_fire ? (N_KEYS'(1) << rpt_key) : '0);
      clr_vec = (load && hit) ? (N_KEYS'(1) << grant) : '0;
      ovf_set = |(set_vec & pend & ~clr_vec);
   end

   always_ff @(posedge clk_raw) begin
      if (rst) begin
         sync1     <= '0;
         sync2     <= '0;
         key_state <= '0;
         key_prev  <= '0;
         for (int i = 0; i < N_KEYS; i++) cnt[i] <= '0;
      end else begin
         sync1    <= keystroke;
         sync2    <= sync1;
         key_prev <= key_state;
         for (int i = 0; i < N_KEYS; i++) begin
            if (sync2[i] == key_state[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
               key_state[i] <= sync2[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   // A set landing on the same cycle as a grant clear wins and is not an overflow.
   always_ff @(posedge clk_raw) begin
      if (rst) begin
         pend       <= '0;
         rep        <= '0;
         ovf        <= 1'b0;
         ev_valid   <= 1'b0;
         ev_key     <= '0;
         ev_repeat  <= 1'b0;
         last_grant <= KW'(N_KEYS - 1);
      end else begin
         pend <= set_vec | (pend & ~clr_vec);
         rep  <= (rep & ~set_vec) | (set_vec & ~press);
         if (ovf_set) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
         if (load) begin
            ev_valid <= hit;
            if (hit) begin
               ev_key     <= grant;
               ev_repeat  <= rep[grant];
               last_grant <= grant;
            end
         end
      end
   end

   always_ff @(posedge clk_raw) begin
      if (rst) begin
         state   <= S_IDLE;
         rpt_key <= '0;
         tmr     <= '0;
      end else if (press_any) begin
         state   <= S_DELAY;
         rpt_key <= press_idx;
         tmr     <= '0;
      end else if (state != S_IDLE && (!key_state[rpt_key] || !rpt_en)) begin
         state <= S_IDLE;
         tmr   <= '0;
      end else if (rpt_fire) begin
         state <= S_RPT;
         tmr   <= '0;
      end else if (state != S_IDLE) begin
         tmr <= tmr + 1'b1;
      end
   end

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus random key traffic, all
// cycles compared against an event-level reference model.
module tb_key_event_arbiter;

   localparam int N  = 12;
   localparam int DB = 4;
   localparam int RD = 20;
   localparam int RP = 8;

   logic          clk_raw = 1'b0;
   logic          rst;
   logic [N-1:0]  keystroke;
   logic          rpt_en, ev_ready, ovf_clr;
   logic          ev_valid;
   logic [3:0]    ev_key;
   logic          ev_repeat;
   logic [N-1:0]  key_state;
   logic          ovf;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [N-1:0] m_s1, m_s2, m_ks, m_ksp;
   int           m_streak [N];
   bit           m_pend [N];
   bit           m_rep [N];
   int           m_lg, m_key;
   bit           m_valid, m_repeat, m_ovf, m_active;
   int           m_rkey;
   longint       m_next, m_edge = 0;

   int     ev_q[$];
   bit     evr_q[$];
   longint evt_q[$];
   longint base;
   logic [N-1:0] mask;

   key_event_arbiter #(.N_KEYS(N), .DB_CYCLES(DB), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut (
      .clk_raw(clk_raw), .rst(rst), .keystroke(keystroke), .rpt_en(rpt_en),
      .ev_ready(ev_ready), .ovf_clr(ovf_clr), .ev_valid(ev_valid), .ev_key(ev_key),
      .ev_repeat(ev_repeat), .key_state(key_state), .ovf(ovf)
   );

   always #5 clk_raw = ~clk_raw;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: one call per clock edge, using the inputs seen at that edge.
   task automatic modelEdge(input logic [N-1:0] ks, input logic rdy, input logic ren,
                            input logic oc, input logic rs);
      int gnt, pidx;
      bit set_k [N];
      bit newrep [N];
      bit ovf_hit, fire, ld;
      m_edge++;
      if (rs) begin
         m_s1 = '0; m_s2 = '0; m_ks = '0; m_ksp = '0;
         for (int i = 0; i < N; i++) begin
            m_streak[i] = 0; m_pend[i] = 0; m_rep[i] = 0;
         end
         m_valid = 0; m_key = 0; m_repeat = 0; m_ovf = 0; m_active = 0;
         m_lg = N - 1; m_rkey = 0; m_next = 0;
         return;
      end
      ld  = !m_valid || rdy;
      gnt = -1;
      if (ld) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_lg + k) % N;
            if (gnt < 0 && m_pend[j]) gnt = j;
         end
      end
      pidx = -1;
      fire = 0;
      for (int i = N - 1; i >= 0; i--) begin
         set_k[i]  = m_ks[i] && !m_ksp[i];
         newrep[i] = 0;
         if (set_k[i]) pidx = i;
      end
      if (pidx >= 0) begin
         m_active = 1; m_rkey = pidx; m_next = m_edge + RD;
      end else if (m_active && (!m_ks[m_rkey] || !ren)) begin
         m_active = 0;
      end else if (m_active && m_edge == m_next) begin
         fire = 1; m_next = m_edge + RP;
      end
      if (fire) begin
         set_k[m_rkey]  = 1;
         newrep[m_rkey] = 1;
      end
      ovf_hit = 0;
      for (int i = 0; i < N; i++) begin
         if (set_k[i] && m_pend[i] && gnt != i) ovf_hit = 1;
      end
      if (ld) begin
         if (gnt >= 0) begin
            m_valid = 1; m_key = gnt; m_repeat = m_rep[gnt]; m_lg = gnt;
         end else begin
            m_valid = 0;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (gnt == i) m_pend[i] = 0;
         if (set_k[i]) begin
            m_pend[i] = 1; m_rep[i] = newrep[i];
         end
      end
      if (ovf_hit) m_ovf = 1;
      else if (oc) m_ovf = 0;
      m_ksp = m_ks;
      for (int i = 0; i < N; i++) begin
         if (m_s2[i] == m_ks[i]) begin
            m_streak[i] = 0;
         end else if (m_streak[i] + 1 == DB) begin
            m_ks[i] = m_s2[i]; m_streak[i] = 0;
         end else begin
            m_streak[i]++;
         end
      end
      m_s2 = m_s1;
      m_s1 = ks;
   endtask

   task automatic checkOutput();
      cmp("ev_valid", 32'(ev_valid), 32'(m_valid));
      cmp("ev_key", 32'(ev_key), 32'(m_key));
      cmp("ev_repeat", 32'(ev_repeat), 32'(m_repeat));
      cmp("key_state", 32'(key_state), 32'(m_ks));
      cmp("ovf", 32'(ovf), 32'(m_ovf));
   endtask

   task automatic applyStimulus(input logic [N-1:0] ks, input logic rdy, input logic ren,
                                input logic oc, input logic rs, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         keystroke = ks; ev_ready = rdy; rpt_en = ren; ovf_clr = oc; rst = rs;
         if (!rs && ev_valid === 1'b1 && rdy) begin
            ev_q.push_back(int'(ev_key));
            evr_q.push_back(ev_repeat);
            evt_q.push_back(m_edge + 1);
         end
         @(posedge clk_raw);
         modelEdge(ks, rdy, ren, oc, rs);
         #1;
         checkOutput();
      end
   endtask

   task automatic clearLog();
      ev_q.delete(); evr_q.delete(); evt_q.delete();
   endtask

   initial begin
      keystroke = '0; rpt_en = 0; ev_ready = 1; ovf_clr = 0; rst = 1;
      applyStimulus('0, 1, 0, 0, 1, 3);
      cmp("reset_valid", 32'(ev_valid), 32'd0);
      cmp("reset_key", 32'(ev_key), 32'd0);

      $display("[TB] single press on key 7");
      clearLog();
      base = m_edge + 1;
      applyStimulus(N'(1) << 7, 1, 0, 0, 0, 30);
      applyStimulus('0, 1, 0, 0, 0, 20);
      cmp("p1_count", 32'(ev_q.size()), 32'd1);
      if (ev_q.size() >= 1) begin
         cmp("p1_key", 32'(ev_q[0]), 32'd7);
         cmp("p1_rep", 32'(evr_q[0]), 32'd0);
         cmp("p1_latency", 32'(evt_q[0] - base), 32'd8);
      end

      $display("[TB] short glitches on key 3");
      clearLog();
      for (int r = 0; r < 7; r++) begin
         applyStimulus(N'(1) << 3, 1, 0, 0, 0, 3);
         applyStimulus('0, 1, 0, 0, 0, 3);
      end
      applyStimulus('0, 1, 0, 0, 0, 10);
      cmp("glitch_count", 32'(ev_q.size()), 32'd0);
      cmp("glitch_state", 32'(key_state[3]), 32'd0);

      $display("[TB] keys 1,5,9 with stalled consumer");
      applyStimulus('0, 1, 0, 0, 1, 2);
      clearLog();
      mask = (N'(1) << 1) | (N'(1) << 5) | (N'(1) << 9);
      applyStimulus(mask, 0, 0, 0, 0, 20);
      cmp("stall_key", 32'(ev_key), 32'd1);
      applyStimulus(mask, 1, 0, 0, 0, 10);
      applyStimulus('0, 1, 0, 0, 0, 15);
      cmp("stall_count", 32'(ev_q.size()), 32'd3);
      if (ev_q.size() == 3) begin
         cmp("stall_ord0", 32'(ev_q[0]), 32'd1);
         cmp("stall_ord1", 32'(ev_q[1]), 32'd5);
         cmp("stall_ord2", 32'(ev_q[2]), 32'd9);
         cmp("stall_gap", 32'(evt_q[2] - evt_q[0]), 32'd2);
      end

      $display("[TB] round robin after grant to key 5");
      applyStimulus(N'(1) << 5, 1, 0, 0, 0, 15);
      applyStimulus('0, 1, 0, 0, 0, 15);
      clearLog();
      applyStimulus(mask, 1, 0, 0, 0, 15);
      applyStimulus('0, 1, 0, 0, 0, 15);
      cmp("rr_count", 32'(ev_q.size()), 32'd3);
      if (ev_q.size() == 3) begin
         cmp("rr_ord0", 32'(ev_q[0]), 32'd9);
         cmp("rr_ord1", 32'(ev_q[1]), 32'd1);
         cmp("rr_ord2", 32'(ev_q[2]), 32'd5);
      end

      $display("[TB] auto-repeat on key 2");
      clearLog();
      applyStimulus(N'(1) << 2, 1, 1, 0, 0, 60);
      applyStimulus('0, 1, 1, 0, 0, 30);
      cmp("rpt_count", 32'(ev_q.size()), 32'd6);
      if (ev_q.size() == 6) begin
         cmp("rpt_first", 32'(evr_q[0]), 32'd0);
         for (int i = 1; i < 6; i++) begin
            cmp($sformatf("rpt_key%0d", i), 32'(ev_q[i]), 32'd2);
            cmp($sformatf("rpt_flag%0d", i), 32'(evr_q[i]), 32'd1);
            cmp($sformatf("rpt_gap%0d", i), 32'(evt_q[i] - evt_q[i-1]), (i == 1) ? 32'(RD) : 32'(RP));
         end
      end

      $display("[TB] random traffic");
      for (int r = 0; r < 60; r++) begin
         logic [N-1:0] m;
         m = N'(1) << $urandom_range(0, N - 1);
         if ($urandom_range(0, 2) == 0) m = m | (N'(1) << $urandom_range(0, N - 1));
         if ($urandom_range(0, 3) == 0) m = '0;
         applyStimulus(m, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 7) == 0, 1'b0, $urandom_range(1, 14));
      end

      $display("[TB] overflow under stall, then reset");
      applyStimulus('0, 1, 0, 0, 1, 2);
      for (int r = 0; r < 3; r++) begin
         applyStimulus(N'(1) << 4, 0, 0, 0, 0, 10);
         applyStimulus('0, 0, 0, 0, 0, 10);
      end
      cmp("ovf_valid", 32'(ev_valid), 32'd1);
      cmp("ovf_key", 32'(ev_key), 32'd4);
      cmp("ovf_flag", 32'(ovf), 32'd1);
      applyStimulus('0, 0, 0, 0, 1, 1);
      cmp("rst_valid", 32'(ev_valid), 32'd0);
      cmp("rst_ovf", 32'(ovf), 32'd0);
      applyStimulus('0, 1, 0, 0, 0, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
